// File: rtl/mem_bus_master.sv
// Purpose: single-transfer memory bus master with a four-phase strobe/ack handshake and a per-phase timeout.
// Latency: done pulses 4 cycles and ready returns 6 cycles after acceptance, given acks registered one cycle after each strobe.
// Backpressure: req is accepted only while ready is high. Each phase waits on its ack for at most TIMEOUT cycles.
//
// Ports:
//   clk, rst_b         clock, asynchronous active-low reset
//   req, we            transfer request, write(1)/read(0) qualifier
//   addr, wdata        word address and write data, latched on acceptance
//   ready              idle and able to accept req
//   done, err          one-cycle completion pulse, one-cycle timeout pulse
//   rdata              last successfully read word
//   cb_out, cb_in      strobes [0]=addr-reg write, [1]=mem write, [2]=mem output-enable, and their acks
//   ab, dob, dib       address bus, data to memory, data from memory
module mem_bus_master #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [2:0]  cb_out,
  input  logic [2:0]  cb_in,
  output logic [31:0] ab,
  output logic [31:0] dob,
  input  logic [31:0] dib
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ADDR  = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] CLEAR = 2'd3;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] count;
  logic          we_q;
  logic          timed_out;
  logic          done_nxt;
  logic          err_nxt;
  logic          rd_load;

  // The edge that would make the count equal TIMEOUT is the edge that aborts,
  // so a silent phase lasts exactly TIMEOUT cycles.
  assign timed_out = (count == LAST_WAIT);

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    rd_load   = 1'b0;
    case (state)
      IDLE: begin
        if (req) state_nxt = ADDR;
      end
      ADDR: begin
        if (cb_in[0]) begin
          state_nxt = DATA;
        end else if (timed_out) begin
          state_nxt = CLEAR;
          done_nxt  = 1'b1;
          err_nxt   = 1'b1;
        end
      end
      DATA: begin
        // Only the ack matching the active strobe counts; the other bit is ignored.
        if (we_q ? cb_in[1] : cb_in[2]) begin
          state_nxt = CLEAR;
          done_nxt  = 1'b1;
          rd_load   = ~we_q;
        end else if (timed_out) begin
          state_nxt = CLEAR;
          done_nxt  = 1'b1;
          err_nxt   = 1'b1;
        end
      end
      CLEAR: begin
        if (cb_in == 3'b000) begin
          state_nxt = IDLE;
        end else if (timed_out) begin
          // Responder never released its acks: report it, but the transfer
          // itself already completed, so no second done.
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      count <= '0;
      we_q  <= 1'b0;
      ab    <= '0;
      dob   <= '0;
      rdata <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
      // Wait counter restarts on every state change and idles at zero.
      if ((state_nxt != state) || (state == IDLE)) begin
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
      // Request fields are captured only on acceptance and then held on the
      // buses until the next acceptance.
      if ((state == IDLE) && req) begin
        we_q <= we;
        ab   <= addr;
        dob  <= wdata;
      end
      if (rd_load) begin
        rdata <= dib;
      end
    end
  end

  assign ready = (state == IDLE);

  // Strobes decode straight from state so reset drops them immediately and
  // the write/read strobes are mutually exclusive by construction.
  always_comb begin
    cb_out = 3'b000;
    case (state)
      ADDR:    cb_out = 3'b001;
      DATA:    cb_out = we_q ? 3'b010 : 3'b100;
      default: cb_out = 3'b000;
    endcase
  end

endmodule
